sbox_share_arbiter: RTL and testbench
=====================================

Name: sbox_share_arbiter

Overview:
Arbitrates one shared SubBytes unit between the AES state datapath (128-bit block) and the key-expansion path (32-bit SubWord).
- Drives the unit's blocoIn and waits a fixed SubBytes latency.
- Captures blocoOut and returns the result to the granted requester with a done/ack handshake.
- Sits between the round controller and the single SubBytes instance, so the design needs only one S-box array.

Parameters:
SBOX_LATENCY, 2, clock edges from loading sb_in to sb_out being valid; legal range 1..31.
CNT_W, 5, width of the latency counter; must satisfy 2^CNT_W > SBOX_LATENCY.

Ports:
clock  in  1  single system clock, rising edge.
reset  in  1  asynchronous, active-low reset (0 = reset asserted).
st_req  in  1  state-path request, level; held high until st_done.
st_block  in  [0:127]  state block; sampled on the accept edge.
st_done  out  1  state result valid; held until st_ack.
st_result  out  [0:127]  SubBytes(st_block).
st_ack  in  1  consumes st_done.
key_req  in  1  key-path request, level.
key_word  in  [0:31]  word to substitute.
key_done  out  1  key result valid; held until key_ack.
key_result  out  [0:31]  SubWord(key_word).
key_ack  in  1  consumes key_done.
sb_in  out  [0:127]  to SubBytes blocoIn.
sb_out  in  [0:127]  from SubBytes blocoOut.
busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (reset=0, async): state=IDLE, cnt=0, last_grant=KEY, sb_in=0, st_result=0, key_result=0, st_done=0, key_done=0, busy=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - On a rising edge with any req high, select a winner (see Optional Feature).
  - Load sb_in: either st_block, or {key_word, 96'h0} with key_word at bits [0:31].
  - Set grant and cnt=0, then go to RUN.
  - With no request, sb_in holds its last value (no toggling).
- RUN:
  - cnt increments each edge.
  - On the edge where cnt==SBOX_LATENCY-1, capture sb_out. State grant takes all 128 bits into st_result; key grant takes sb_out[0:31] into key_result.
  - Set the matching done, update last_grant, go to DONE.
  - Result is visible exactly SBOX_LATENCY edges after the accept edge.
- DONE:
  - done stays high and the result stays stable until the matching ack is high on an edge; then done=0 and state goes to IDLE.
  - The other requester is not serviced during DONE.
  - ack and a pending req on the same edge: go to IDLE, then accept on the next edge (one bubble cycle).
- ack while not done: ignored.
- req dropped mid-RUN: the operation still completes and done is still raised. Requesters must not do this; the bench flags it as a protocol error.
- reset asserted mid-RUN/DONE: immediate return to reset values; the in-flight result is discarded.
- Only one done is ever high at a time; st_result/key_result keep their value after ack until overwritten.

Optional Feature:
Macro SBOX_ARB_ROUND_ROBIN_EN.
- Defined: round-robin. When both req are high in IDLE, grant the requester opposite to last_grant. The first contention after reset goes to STATE.
- Undefined: fixed priority, KEY always wins over STATE (key schedule never stalls). last_grant is still kept but unused.

Decomposition:
- Shared package sbox_arb_pkg holds:
  - state encoding localparams S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2;
  - grant encoding G_STATE=1'b0, G_KEY=1'b1;
  - KEY_PAD_W=96.
- One natural sub-module, sbox_arb_pick: combinational winner select from st_req, key_req, last_grant, with the macro-dependent logic inside it.
- The SubBytes unit stays outside; the arbiter only drives its ports.

Test Plan:
- State only, SBOX_LATENCY=2: st_block=19a09ae93df4c6f8e3e28d48be2b2a08, st_req=1.
  - st_done rises 2 edges after accept.
  - st_result = d4e0b81e27bfb44111985d52aef1e530.
  - Hold st_ack=0 for 5 cycles: result stable. Then ack: st_done=0, busy=0.
- Key only: key_word=cf4f3c09 -> key_result=8a84eb01.
  - sb_in[32:127]=0 during RUN; st_done stays 0.
- Contention, both req high from reset, with SBOX_ARB_ROUND_ROBIN_EN:
  - grants alternate STATE, KEY, STATE.
  - Second state block a4686b029c9f5b6a7f35ea50f22b4349 -> 49457f77dedb3902d2968753 89f11a3b.
  - Without the macro: KEY is granted every time key_req is high.
- Ack + req on the same edge: exactly one IDLE cycle, then the new accept; busy shows a 1-cycle low.
- Reset low mid-RUN (cnt=1): all outputs return to 0 asynchronously, before the next clock edge. After release, a fresh request completes normally with the correct SubBytes value.
- SBOX_LATENCY=5 sweep: done arrives exactly 5 edges after accept. An ack before done has no effect.

Source files
------------

// File: rtl/sbox_arb_pkg.sv
// Shared encodings for the SubBytes share arbiter and its winner-select helper.
// No logic of its own; constants and a key-padding helper only.
// Not applicable (no handshake in a package).
package sbox_arb_pkg;

    // FSM state encoding
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Grant encoding, also used for last_grant
    localparam logic G_STATE = 1'b0;
    localparam logic G_KEY   = 1'b1;

    // Zero bits appended after a 32-bit key word to fill the 128-bit S-box input
    localparam int KEY_PAD_W = 96;

    // Place a key word in bits [0:31] of the S-box input, rest zero
    function automatic logic [0:127] pad_key(input logic [0:31] word);
        return {word, {KEY_PAD_W{1'b0}}};
    endfunction

endpackage

// File: rtl/sbox_arb_pick.sv
// Combinational winner select between state and key requests; SBOX_ARB_ROUND_ROBIN_EN picks policy.
// Latency: zero (pure combinational).
// Backpressure: none; the caller only samples the result while idle.
module sbox_arb_pick
    import sbox_arb_pkg::*;
(
    input  logic st_req,
    input  logic key_req,
    input  logic last_grant,
    output logic any_req,
    output logic winner
);

    assign any_req = st_req | key_req;

`ifdef SBOX_ARB_ROUND_ROBIN_EN
    // Contention goes to the side that was not served last; a lone request always wins
    always_comb begin
        winner = G_STATE;
        if (st_req && key_req) begin
            winner = (last_grant == G_KEY) ? G_STATE : G_KEY;
        end else if (key_req) begin
            winner = G_KEY;
        end
    end
`else
    // Key schedule has absolute priority so it never stalls; history is not consulted
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    always_comb begin
        winner = G_STATE;
        if (key_req) begin
            winner = G_KEY;
        end
    end
`endif

endmodule

// File: rtl/sbox_share_arbiter.sv
// Shares one SubBytes unit between the 128-bit state path and the 32-bit key SubWord path.
// Latency: result/done visible SBOX_LATENCY edges after the accept edge; one IDLE bubble between jobs.
// Backpressure: done and result hold until the matching ack; the other requester waits meanwhile.
// Build option: define SBOX_ARB_ROUND_ROBIN_EN for round-robin, otherwise KEY has fixed priority.
module sbox_share_arbiter
    import sbox_arb_pkg::*;
#(
    parameter int SBOX_LATENCY = 2,
    parameter int CNT_W        = 5
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           st_req,
    input  logic [0:127]   st_block,
    output logic           st_done,
    output logic [0:127]   st_result,
    input  logic           st_ack,
    input  logic           key_req,
    input  logic [0:31]    key_word,
    output logic           key_done,
    output logic [0:31]    key_result,
    input  logic           key_ack,
    output logic [0:127]   sb_in,
    input  logic [0:127]   sb_out,
    output logic           busy
);

    // Counter value on the edge where sb_out holds the result of the loaded input
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SBOX_LATENCY - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             grant;
    logic             last_grant;
    logic             any_req;
    logic             winner;
    logic             ack_hit;

    sbox_arb_pick u_pick (
        .st_req     (st_req),
        .key_req    (key_req),
        .last_grant (last_grant),
        .any_req    (any_req),
        .winner     (winner)
    );

    // Only the granted side's ack can release DONE; a stray ack is ignored
    assign ack_hit = (grant == G_KEY) ? key_ack : st_ack;

    assign busy = (state != S_IDLE);

    // Accept, wait out the S-box latency, capture, then hold the result until acked
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            grant      <= G_STATE;
            last_grant <= G_KEY;
            sb_in      <= '0;
            st_result  <= '0;
            key_result <= '0;
            st_done    <= 1'b0;
            key_done   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    // sb_in is only rewritten on accept so the S-box input stays quiet when idle
                    if (any_req) begin
                        grant <= winner;
                        cnt   <= '0;
                        state <= S_RUN;
                        sb_in <= (winner == G_KEY) ? pad_key(key_word) : st_block;
                    end
                end
                S_RUN: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == LAST_CNT) begin
                        if (grant == G_KEY) begin
                            key_result <= sb_out[0:31];
                            key_done   <= 1'b1;
                        end else begin
                            st_result <= sb_out;
                            st_done   <= 1'b1;
                        end
                        last_grant <= grant;
                        state      <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (ack_hit) begin
                        st_done  <= 1'b0;
                        key_done <= 1'b0;
                        state    <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sbox_share_arbiter.sv
// Self-checking bench: two arbiter instances (latency 2 and 5) with behavioural S-box pipelines.
// Latency: n/a.
// Backpressure: ack timing randomised; requests held until done.
module tb_sbox_share_arbiter;

    localparam int LAT_A = 2;

    localparam logic [0:2047] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:127] BLK1 = 128'h19a09ae93df4c6f8e3e28d48be2b2a08;
    localparam logic [0:127] RES1 = 128'hd4e0b81e27bfb44111985d52aef1e530;
    localparam logic [0:127] BLK2 = 128'ha4686b029c9f5b6a7f35ea50f22b4349;
    localparam logic [0:127] RES2 = 128'h49457f77dedb3902d296875389f11a3b;
    localparam logic [0:31]  KW1  = 32'hcf4f3c09;
    localparam logic [0:31]  KR1  = 32'h8a84eb01;

    logic clk = 1'b0;
    logic rst_n;

    logic         a_st_req, a_st_ack, a_key_req, a_key_ack;
    logic [0:127] a_st_block, a_st_result, a_sb_in, a_sb_out;
    logic [0:31]  a_key_word, a_key_result;
    logic         a_st_done, a_key_done, a_busy;

    logic         b_st_req, b_st_ack, b_key_req, b_key_ack;
    logic [0:127] b_st_block, b_st_result, b_sb_in, b_sb_out;
    logic [0:31]  b_key_word, b_key_result;
    logic         b_st_done, b_key_done, b_busy;

    int checks = 0;
    int errors = 0;

    // Reference-model state: pending requests and their data, last served side (1 = key)
    bit           want_st, want_key;
    logic [0:127] st_blk;
    logic [0:31]  key_wd;
    bit           model_last;

    always #5 clk = ~clk;

    sbox_share_arbiter #(.SBOX_LATENCY(LAT_A), .CNT_W(5)) dut_a (
        .clock(clk), .reset(rst_n),
        .st_req(a_st_req), .st_block(a_st_block), .st_done(a_st_done),
        .st_result(a_st_result), .st_ack(a_st_ack),
        .key_req(a_key_req), .key_word(a_key_word), .key_done(a_key_done),
        .key_result(a_key_result), .key_ack(a_key_ack),
        .sb_in(a_sb_in), .sb_out(a_sb_out), .busy(a_busy)
    );

    sbox_share_arbiter #(.SBOX_LATENCY(5), .CNT_W(5)) dut_b (
        .clock(clk), .reset(rst_n),
        .st_req(b_st_req), .st_block(b_st_block), .st_done(b_st_done),
        .st_result(b_st_result), .st_ack(b_st_ack),
        .key_req(b_key_req), .key_word(b_key_word), .key_done(b_key_done),
        .key_result(b_key_result), .key_ack(b_key_ack),
        .sb_in(b_sb_in), .sb_out(b_sb_out), .busy(b_busy)
    );

    function automatic logic [0:127] subbytes(input logic [0:127] x);
        logic [0:127] y;
        int idx;
        y = '0;
        for (int i = 0; i < 16; i++) begin
            idx = int'(x[i*8 +: 8]);
            y[i*8 +: 8] = SBOX_TBL[idx*8 +: 8];
        end
        return y;
    endfunction

    // Behavioural SubBytes units: latency 2 (one register) and latency 5 (four registers)
    logic [0:127] a_pipe;
    logic [0:127] b_pipe [0:3];
    always @(posedge clk) begin
        a_pipe <= subbytes(a_sb_in);
        b_pipe[0] <= subbytes(b_sb_in);
        for (int i = 1; i < 4; i++) b_pipe[i] <= b_pipe[i-1];
    end
    assign a_sb_out = a_pipe;
    assign b_sb_out = b_pipe[3];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    task automatic model_reset();
        want_st = 1'b0;
        want_key = 1'b0;
        model_last = 1'b1;
        a_st_req = 1'b0;
        a_key_req = 1'b0;
        a_st_ack = 1'b0;
        a_key_ack = 1'b0;
    endtask

    // One complete transaction on instance A from accept to ack, checked against the model
    task automatic serve(input int hold, output bit win);
        bit           exp_key;
        logic [0:127] exp_in, exp_res;
        if (want_st && want_key) begin
`ifdef SBOX_ARB_ROUND_ROBIN_EN
            exp_key = !model_last;
`else
            exp_key = 1'b1;
`endif
        end else begin
            exp_key = want_key;
        end
        a_st_req   = want_st;
        a_key_req  = want_key;
        a_st_block = st_blk;
        a_key_word = key_wd;
        exp_in  = exp_key ? {key_wd, 96'h0} : st_blk;
        exp_res = subbytes(exp_in);

        step();
        chk("busy_after_accept", a_busy, 1);
        chk("sb_in_loaded", a_sb_in, exp_in);
        for (int i = 1; i < LAT_A; i++) begin
            step();
            chk("done_before_latency", {a_st_done, a_key_done}, 0);
        end
        step();
        chk("done_flags", {a_st_done, a_key_done}, exp_key ? 2'b01 : 2'b10);
        if (exp_key) chk("key_result", a_key_result, exp_res[0:31]);
        else         chk("st_result", a_st_result, exp_res);

        model_last = exp_key;
        if (exp_key) begin want_key = 1'b0; a_key_req = 1'b0; end
        else         begin want_st = 1'b0;  a_st_req = 1'b0;  end

        for (int h = 0; h < hold; h++) begin
            if (exp_key) a_st_ack = 1'($urandom % 2);
            else         a_key_ack = 1'($urandom % 2);
            step();
            chk("done_held", {a_st_done, a_key_done}, exp_key ? 2'b01 : 2'b10);
            if (exp_key) chk("key_result_stable", a_key_result, exp_res[0:31]);
            else         chk("st_result_stable", a_st_result, exp_res);
        end
        a_st_ack  = !exp_key;
        a_key_ack = exp_key;
        step();
        chk("done_cleared", {a_st_done, a_key_done}, 0);
        chk("busy_bubble", a_busy, 0);
        a_st_ack  = 1'b0;
        a_key_ack = 1'b0;
        win = exp_key;
    endtask

    initial begin
        bit           w;
        bit [2:0]     seq;
        logic [0:127] bblk;

        rst_n = 1'b1;
        model_reset();
        a_st_block = '0; a_key_word = '0;
        b_st_req = 1'b0; b_st_ack = 1'b0; b_key_req = 1'b0; b_key_ack = 1'b0;
        b_st_block = '0; b_key_word = '0;
        st_blk = '0; key_wd = '0;
        #2 rst_n = 1'b0;
        #2;
        chk("reset_busy", a_busy, 0);
        chk("reset_done", {a_st_done, a_key_done}, 0);
        chk("reset_st_result", a_st_result, 0);
        chk("reset_key_result", a_key_result, 0);
        chk("reset_sb_in", a_sb_in, 0);
        chk("reset_b_busy", b_busy, 0);
        step();
        rst_n = 1'b1;
        step();

        // Directed state-only job with long ack hold
        want_st = 1'b1; st_blk = BLK1;
        serve(5, w);
        chk("state_only_grant", w, 0);
        chk("state_only_const", a_st_result, RES1);

        // Directed key-only job
        want_key = 1'b1; key_wd = KW1;
        serve(0, w);
        chk("key_only_grant", w, 1);
        chk("key_only_const", a_key_result, KR1);

        // Contention from a fresh reset
        rst_n = 1'b0;
        model_reset();
        step();
        rst_n = 1'b1;
        want_st = 1'b1; st_blk = BLK1;
        want_key = 1'b1; key_wd = KW1;
        for (int k = 0; k < 3; k++) begin
            serve(1, w);
            seq[2-k] = w;
            if (!want_st)  begin want_st = 1'b1;  st_blk = BLK2; end
            if (!want_key) begin want_key = 1'b1; end
        end
`ifdef SBOX_ARB_ROUND_ROBIN_EN
        chk("contention_sequence", seq, 3'b010);
        chk("second_block_const", a_st_result, RES2);
`else
        chk("contention_sequence", seq, 3'b111);
        chk("key_result_after_contention", a_key_result, KR1);
`endif

        // Randomised traffic with pending requests carried between jobs
        for (int t = 0; t < 40; t++) begin
            if (!want_st && ($urandom % 2 == 1)) begin
                want_st = 1'b1; st_blk = {$urandom, $urandom, $urandom, $urandom};
            end
            if (!want_key && ($urandom % 2 == 1)) begin
                want_key = 1'b1; key_wd = $urandom;
            end
            if (!want_st && !want_key) begin
                want_st = 1'b1; st_blk = {$urandom, $urandom, $urandom, $urandom};
            end
            serve(int'($urandom % 4), w);
        end

        // Asynchronous reset while the counter is at 1
        want_st = 1'b0; want_key = 1'b0;
        a_key_req = 1'b0;
        a_st_req = 1'b1; a_st_block = BLK2;
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("midrun_reset_busy", a_busy, 0);
        chk("midrun_reset_done", {a_st_done, a_key_done}, 0);
        chk("midrun_reset_sb_in", a_sb_in, 0);
        chk("midrun_reset_st_result", a_st_result, 0);
        chk("midrun_reset_key_result", a_key_result, 0);
        model_reset();
        step();
        rst_n = 1'b1;
        want_st = 1'b1; st_blk = BLK2;
        serve(2, w);
        chk("after_reset_const", a_st_result, RES2);

        // Latency-5 instance with an early ack that must be ignored
        bblk = {$urandom, $urandom, $urandom, $urandom};
        b_st_block = bblk;
        b_st_req = 1'b1;
        b_st_ack = 1'b1;
        step();
        chk("lat5_busy", b_busy, 1);
        for (int i = 1; i < 5; i++) begin
            step();
            chk("lat5_no_early_done", b_st_done, 0);
        end
        step();
        chk("lat5_done", b_st_done, 1);
        chk("lat5_result", b_st_result, subbytes(bblk));
        chk("lat5_key_done_low", b_key_done, 0);
        b_st_req = 1'b0;
        b_st_ack = 1'b0;
        step();
        chk("lat5_done_held", b_st_done, 1);
        b_st_ack = 1'b1;
        step();
        chk("lat5_done_cleared", b_st_done, 0);
        chk("lat5_idle", b_busy, 0);
        b_st_ack = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
